mul_err_monitor: RTL and testbench

- Receiving end of the approximate-multiplier characterisation flow: consumes a stream of (a, b, approximate result) samples from the 9x9 signed approximate multiplier path.
- Recomputes the exact signed product and accumulates error statistics in hardware over one sweep.
- The host arms it with start_i, streams samples, flags the last one, then reads stable statistics while done_o is high.

---
 rtl/mul_err_monitor.sv | 162 ++++++++++++++++
 tb/tb_mul_err_monitor.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_err_monitor.sv
// mul_err_monitor: error-statistics collector for the 9x9 signed approximate
// multiplier path. For each accepted (a, b, approximate result) sample it
// recomputes the exact product, registers the signed and absolute error, and
// folds them into the sweep statistics one edge later.
module mul_err_monitor #(
  parameter  int MAC_IN_WIDTH  = 9,
  parameter  int CNT_WIDTH     = 20,
  parameter  int ACC_WIDTH     = 40,
  localparam int MAC_OUT_WIDTH = 2 * MAC_IN_WIDTH
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       start_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [MAC_IN_WIDTH-1:0]    a_i,
  input  logic [MAC_IN_WIDTH-1:0]    b_i,
  input  logic [MAC_OUT_WIDTH-1:0]   res_i,
  input  logic                       last_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic [CNT_WIDTH-1:0]       n_samples_o,
  output logic [CNT_WIDTH-1:0]       n_err_o,
  output logic [ACC_WIDTH-1:0]       sum_abs_err_o,
  output logic [ACC_WIDTH-1:0]       sum_err_o,
  output logic [MAC_OUT_WIDTH:0]     max_abs_err_o,
  output logic                       ovf_o
);

  // One extra bit over the product width so res - exact never overflows.
  localparam int ERR_WIDTH = MAC_OUT_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_reg, state_next;

  logic arm;
  logic xfer;

  logic signed [ERR_WIDTH-1:0] a_ext, b_ext, res_ext;
  logic signed [ERR_WIDTH-1:0] exact;
  logic signed [ERR_WIDTH-1:0] err;
  logic        [ERR_WIDTH-1:0] abs_err;

  logic                        s1_valid_reg;
  logic signed [ERR_WIDTH-1:0] err_reg;
  logic        [ERR_WIDTH-1:0] abs_err_reg;

  logic [CNT_WIDTH-1:0] n_samples_reg;
  logic [CNT_WIDTH-1:0] n_err_reg;
  logic [ACC_WIDTH-1:0] sum_abs_reg;
  logic [ACC_WIDTH-1:0] sum_err_reg;
  logic [ERR_WIDTH-1:0] max_abs_reg;
  logic                 ovf_reg;

  logic [ACC_WIDTH:0]   sum_abs_wide;
  logic                 err_nonzero;

  // start_i is only honoured when no sweep is in flight.
  assign arm  = start_i && ((state_reg == IDLE) || (state_reg == DONE));
  assign xfer = valid_i && ready_o;

  // Sign-extend everything to the error width before the arithmetic.
  assign a_ext   = ERR_WIDTH'($signed(a_i));
  assign b_ext   = ERR_WIDTH'($signed(b_i));
  assign res_ext = ERR_WIDTH'($signed(res_i));
  assign exact   = a_ext * b_ext;
  assign err     = res_ext - exact;
  assign abs_err = err[ERR_WIDTH-1] ? unsigned'(-err) : unsigned'(err);

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // Next-state logic: DRAIN lasts exactly one cycle to flush stage 2.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = RUN;
      RUN:     if (xfer && last_i) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start_i) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so ready_o never depends on valid_i.
  always_comb begin
    ready_o = (state_reg == RUN);
    busy_o  = (state_reg == RUN) || (state_reg == DRAIN);
    done_o  = (state_reg == DONE);
  end

  // Stage 1: capture the error of each accepted sample.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_reg <= 1'b0;
      err_reg      <= '0;
      abs_err_reg  <= '0;
    end else begin
      s1_valid_reg <= xfer;
      if (xfer) begin
        err_reg     <= err;
        abs_err_reg <= abs_err;
      end
    end
  end

  assign sum_abs_wide = {1'b0, sum_abs_reg} + (ACC_WIDTH + 1)'(abs_err_reg);
  assign err_nonzero  = (err_reg != '0);

  // Stage 2: fold the registered error into the statistics; arming a sweep clears them.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      n_samples_reg <= '0;
      n_err_reg     <= '0;
      sum_abs_reg   <= '0;
      sum_err_reg   <= '0;
      max_abs_reg   <= '0;
      ovf_reg       <= 1'b0;
    end else if (arm) begin
      n_samples_reg <= '0;
      n_err_reg     <= '0;
      sum_abs_reg   <= '0;
      sum_err_reg   <= '0;
      max_abs_reg   <= '0;
      ovf_reg       <= 1'b0;
    end else if (s1_valid_reg) begin
      n_samples_reg <= n_samples_reg + 1'b1;
      if (&n_samples_reg) ovf_reg <= 1'b1;
      if (err_nonzero) begin
        n_err_reg <= n_err_reg + 1'b1;
        if (&n_err_reg) ovf_reg <= 1'b1;
      end
      // Absolute-error sum saturates instead of wrapping.
      if (sum_abs_wide[ACC_WIDTH]) begin
        sum_abs_reg <= '1;
        ovf_reg     <= 1'b1;
      end else begin
        sum_abs_reg <= sum_abs_wide[ACC_WIDTH-1:0];
      end
      // Bias sum wraps; err_reg is signed so the cast sign-extends.
      sum_err_reg <= sum_err_reg + ACC_WIDTH'(err_reg);
      if (abs_err_reg > max_abs_reg) max_abs_reg <= abs_err_reg;
    end
  end

  assign n_samples_o   = n_samples_reg;
  assign n_err_o       = n_err_reg;
  assign sum_abs_err_o = sum_abs_reg;
  assign sum_err_o     = sum_err_reg;
  assign max_abs_err_o = max_abs_reg;
  assign ovf_o         = ovf_reg;

endmodule

// File: tb/tb_mul_err_monitor.sv
// Directed bench for mul_err_monitor: a default instance plus an instance
// with a 20-bit accumulator, both driven by the same stimulus.
module tb_mul_err_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        valid = 1'b0;
  logic        last = 1'b0;
  logic [8:0]  a_in = '0;
  logic [8:0]  b_in = '0;
  logic [17:0] res_in = '0;

  logic        ready, busy, done, ovf;
  logic [19:0] n_samples, n_err;
  logic [39:0] sum_abs, sum_err;
  logic [18:0] max_abs;

  logic        s_ready, s_busy, s_done, s_ovf;
  logic [19:0] s_n_samples, s_n_err;
  logic [19:0] s_sum_abs, s_sum_err;
  logic [18:0] s_max_abs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mul_err_monitor u_dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .ready_o(ready),
    .a_i(a_in), .b_i(b_in), .res_i(res_in), .last_i(last),
    .busy_o(busy), .done_o(done), .n_samples_o(n_samples), .n_err_o(n_err),
    .sum_abs_err_o(sum_abs), .sum_err_o(sum_err), .max_abs_err_o(max_abs), .ovf_o(ovf)
  );

  mul_err_monitor #(.ACC_WIDTH(20)) u_sat (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .valid_i(valid), .ready_o(s_ready),
    .a_i(a_in), .b_i(b_in), .res_i(res_in), .last_i(last),
    .busy_o(s_busy), .done_o(s_done), .n_samples_o(s_n_samples), .n_err_o(s_n_err),
    .sum_abs_err_o(s_sum_abs), .sum_err_o(s_sum_err), .max_abs_err_o(s_max_abs), .ovf_o(s_ovf)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  // Pulse start_i for one edge; returns at the negedge after it.
  task automatic start_sweep();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present one sample for one edge; returns at the negedge after it.
  task automatic send(input logic signed [8:0] a, input logic signed [8:0] b,
                      input logic signed [17:0] r, input logic l);
    valid  = 1'b1;
    a_in   = a;
    b_in   = b;
    res_in = r;
    last   = l;
    @(negedge clk);
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".ready"}, ready, 0);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".done"}, done, 0);
    check({tag, ".n_samples"}, n_samples, 0);
    check({tag, ".n_err"}, n_err, 0);
    check({tag, ".sum_abs"}, sum_abs, 0);
    check({tag, ".sum_err"}, sum_err, 0);
    check({tag, ".max_abs"}, max_abs, 0);
    check({tag, ".ovf"}, ovf, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Exact sweep: four exact products
    start_sweep();
    check("exact.ready_run", ready, 1);
    check("exact.busy_run", busy, 1);
    send(3, 5, 15, 0);
    send(-256, -256, 65536, 0);
    send(-1, 7, -7, 0);
    send(0, 0, 0, 1);
    check("exact.drain_ready", ready, 0);
    check("exact.drain_busy", busy, 1);
    check("exact.drain_done", done, 0);
    @(negedge clk);
    check("exact.done", done, 1);
    check("exact.busy_done", busy, 0);
    check("exact.n_samples", n_samples, 4);
    check("exact.n_err", n_err, 0);
    check("exact.sum_abs", sum_abs, 0);
    check("exact.sum_err", sum_err, 0);
    check("exact.max_abs", max_abs, 0);

    // Restart from DONE clears on the arming edge; then biased errors -1, +4, -10
    start_sweep();
    check("restart.n_samples_clr", n_samples, 0);
    check("restart.busy", busy, 1);
    send(2, 3, 5, 0);
    send(-4, 4, -12, 0);
    send(10, 10, 90, 1);
    @(negedge clk);
    check("bias.done", done, 1);
    check("bias.n_samples", n_samples, 3);
    check("bias.n_err", n_err, 3);
    check("bias.sum_abs", sum_abs, 15);
    check("bias.sum_err", sum_err, 40'hFF_FFFF_FFF9);
    check("bias.max_abs", max_abs, 10);

    // Single sample after a 3-cycle gap, then valid while not ready
    start_sweep();
    repeat (3) @(negedge clk);
    check("single.gap_n", n_samples, 0);
    send(1, 1, 1, 1);
    check("single.drain_ready", ready, 0);
    check("single.drain_done", done, 0);
    @(negedge clk);
    check("single.done", done, 1);
    check("single.done_ready", ready, 0);
    check("single.n_samples", n_samples, 1);
    valid = 1'b1;
    repeat (3) @(negedge clk);
    valid = 1'b0;
    check("single.extra_valid_n", n_samples, 1);
    check("single.still_done", done, 1);

    // Async reset mid-RUN after 5 transfers of err +2
    start_sweep();
    for (int i = 0; i < 5; i++) send(1, 1, 3, 0);
    check("midrst.pre_n", n_samples, 4);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst.idle_ready", ready, 0);
    start_sweep();
    send(6, -7, -42, 1);
    @(negedge clk);
    check("midrst.done", done, 1);
    check("midrst.n_samples", n_samples, 1);
    check("midrst.n_err", n_err, 0);

    // start_i during RUN is ignored
    start_sweep();
    send(1, 1, 2, 0);
    send(2, 2, 4, 0);
    start = 1'b1;
    send(3, 3, 9, 0);
    start = 1'b0;
    send(-2, 3, -5, 1);
    @(negedge clk);
    check("runstart.done", done, 1);
    check("runstart.n_samples", n_samples, 4);
    check("runstart.n_err", n_err, 2);
    check("runstart.sum_err", sum_err, 2);
    check("runstart.max_abs", max_abs, 1);

    // Saturation: ten samples of |err| = 131072
    start_sweep();
    for (int i = 0; i < 9; i++) send(0, 0, -131072, 0);
    send(0, 0, -131072, 1);
    @(negedge clk);
    check("sat.done", s_done, 1);
    check("sat.sum_abs", s_sum_abs, 20'hFFFFF);
    check("sat.ovf", s_ovf, 1);
    check("sat.max_abs", s_max_abs, 131072);
    check("sat.wide_sum_abs", sum_abs, 1310720);
    check("sat.wide_ovf", ovf, 0);
    check("sat.wide_sum_err", sum_err, 40'hFF_FFEC_0000);
    repeat (5) @(negedge clk);
    check("sat.ovf_sticky", s_ovf, 1);
    check("sat.sum_abs_hold", s_sum_abs, 20'hFFFFF);
    start_sweep();
    check("sat.ovf_clr", s_ovf, 0);
    check("sat.sum_abs_clr", s_sum_abs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
